// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the RV32 fetch/data memory arbiter.
package rv32_mem_pkg;

  // Arbiter FSM states: IDLE picks a winner, REQ drives the memory request
  // until it is accepted, WAIT holds until the single response returns.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Owner of the outstanding transaction.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Consecutive data grants allowed while a fetch is waiting.
  localparam int MAX_STREAK_DEFAULT = 4;

  // Width of a counter that must hold the values 0..max_streak.
  function automatic int streak_width(input int max_streak);
    if (max_streak < 1) begin
      return 1;
    end
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/rv32_arb_select.sv
// Combinational winner selection between the fetch and data requesters.
// Data normally wins; a waiting fetch wins once data has taken MAX_STREAK
// grants in a row while it waited.
module rv32_arb_select
  import rv32_mem_pkg::*;
#(
  parameter int MAX_STREAK = MAX_STREAK_DEFAULT,
  parameter int SW         = streak_width(MAX_STREAK)
) (
  input  logic          i_if_req,
  input  logic          i_d_req,
  input  logic [SW-1:0] i_streak,
  output logic          o_valid,
  output logic          o_owner
);

  logic w_fetch_starved;

  assign w_fetch_starved = (i_streak == SW'(MAX_STREAK));

  // Pick the winner from the live requests and the starvation counter
  always_comb begin
    o_valid = i_if_req | i_d_req;
    o_owner = OWN_D;
    if (i_if_req && (!i_d_req || w_fetch_starved)) begin
      o_owner = OWN_IF;
    end
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter in front of a single memory
// port with at most one transaction outstanding.
//
// Handshake semantics: a requester raises *_req with its fields stable and
// holds them until the arbiter answers with a one-cycle *_gnt pulse (only in
// IDLE, never both at once). Toward memory, mem_req and its fields are
// registered and held until the cycle mem_gnt is high; exactly one
// mem_rvalid follows per accepted request, possibly in the mem_gnt cycle
// itself. mem_rvalid seen while no request is accepted is ignored. The
// response is routed combinationally to the owner's *_rvalid/*_rdata.
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = MAX_STREAK_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  // instruction fetch port
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  // data port
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  // shared memory port
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  // observability
  output state_t          dbg_state
);

  localparam int SW = streak_width(MAX_STREAK);
  localparam int BW = DW / 8;

  state_t          r_state;
  state_t          w_next_state;
  logic [SW-1:0]   r_streak;
  logic            r_owner;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [BW-1:0]   r_mem_wstrb;

  logic            w_sel_valid;
  logic            w_sel_owner;
  logic            w_grant;
  logic            w_resp;

  rv32_arb_select #(
    .MAX_STREAK (MAX_STREAK),
    .SW         (SW)
  ) u_select (
    .i_if_req (if_req),
    .i_d_req  (d_req),
    .i_streak (r_streak),
    .o_valid  (w_sel_valid),
    .o_owner  (w_sel_owner)
  );

  // Next state, grant strobe and response strobe
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_resp       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_valid) begin
          w_grant      = 1'b1;
          w_next_state = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (mem_rvalid) begin
            w_resp       = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          w_resp       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the winner's fields on grant; drop mem_req once memory accepts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= OWN_IF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else if (w_grant) begin
      r_owner   <= w_sel_owner;
      r_mem_req <= 1'b1;
      if (w_sel_owner == OWN_IF) begin
        r_mem_we    <= 1'b0;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= '0;
        r_mem_wstrb <= '0;
      end else begin
        r_mem_we    <= d_we;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
        r_mem_wstrb <= d_wstrb;
      end
    end else if ((r_state == REQ) && mem_gnt) begin
      r_mem_req <= 1'b0;
    end
  end

  // Count data grants taken while a fetch was waiting, saturating at MAX_STREAK
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_streak <= '0;
    end else if (w_grant) begin
      if (w_sel_owner == OWN_IF || !if_req) begin
        r_streak <= '0;
      end else if (r_streak < SW'(MAX_STREAK)) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end

  assign if_gnt    = w_grant && (w_sel_owner == OWN_IF);
  assign d_gnt     = w_grant && (w_sel_owner == OWN_D);

  assign if_rvalid = w_resp && (r_owner == OWN_IF);
  assign d_rvalid  = w_resp && (r_owner == OWN_D);
  assign if_rdata  = (r_owner == OWN_IF) ? mem_rdata : '0;
  assign d_rdata   = (r_owner == OWN_D)  ? mem_rdata : '0;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

  assign dbg_state = r_state;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench for rv32_mem_arbiter: requester drivers, a memory
// responder with its own storage, and a transaction-level reference model
// feeding a scoreboard that the monitor drains on every DUT response.
module tb_rv32_mem_arbiter;
  import rv32_mem_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXS = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic reset_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- DUT
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [BW-1:0] d_wstrb;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_wstrb;
  state_t        dbg_state;

  rv32_mem_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MAXS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_wstrb    (d_wstrb),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------- bookkeeping
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected response queue entries: {owner, is_write, read_data}
  logic [DW+1:0] exp_q[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] wstrb;
  } mem_exp_t;
  mem_exp_t exp_mem_q[$];

  logic grant_log[$];
  logic [DW-1:0] last_if_rdata, last_d_rdata;

  // Two independent word stores: the responder's physical memory and the
  // reference memory the scoreboard predicts from.
  logic [DW-1:0] phys_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem  [logic [AW-1:0]];

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] st);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] phys_rd(input logic [AW-1:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    phys_mem[a] = v;
    ref_mem[a]  = v;
  endtask

  // ---------------------------------------------------------------- memory responder
  int cfg_gd   = -1;  // cycles before mem_gnt, -1 = random
  int cfg_rd   = -1;  // cycles from mem_gnt to mem_rvalid, -1 = random
  bit cfg_spur = 0;   // inject stray mem_rvalid pulses

  initial begin
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rsp;
    logic [BW-1:0] c_wstrb;
    int gd, rd;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        if (cfg_spur && $urandom_range(0, 5) == 0) begin
          @(posedge clk); #1;
          mem_rvalid = 1; mem_rdata = $urandom;
          @(posedge clk); #1;
          mem_rvalid = 0;
        end
        continue;
      end
      c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata; c_wstrb = mem_wstrb;
      gd = (cfg_gd >= 0) ? cfg_gd : $urandom_range(0, 2);
      rd = (cfg_rd >= 0) ? cfg_rd : $urandom_range(0, 2);
      for (int i = 0; i < gd; i++) begin
        @(posedge clk); #1;
        mem_rvalid = cfg_spur && ($urandom_range(0, 2) == 0);
        mem_rdata  = $urandom;
      end
      if (c_we) begin
        phys_mem[c_addr] = merge(phys_rd(c_addr), c_wdata, c_wstrb);
        c_rsp = $urandom;
      end else begin
        c_rsp = phys_rd(c_addr);
      end
      @(posedge clk); #1;
      mem_gnt = 1; mem_rvalid = (rd == 0); mem_rdata = c_rsp;
      @(posedge clk); #1;
      mem_gnt = 0; mem_rvalid = 0;
      if (rd > 0) begin
        for (int i = 0; i < rd - 1; i++) begin
          @(posedge clk); #1;
        end
        mem_rvalid = 1; mem_rdata = c_rsp;
        @(posedge clk); #1;
        mem_rvalid = 0;
      end
    end
  end

  // ---------------------------------------------------------------- monitor / scoreboard
  // Transaction view of the port: free -> granted (memory request pending)
  // -> accepted (response pending) -> free the cycle after the response.
  int  mphase = 0;   // 0 free, 1 request pending, 2 response pending
  int  skips  = 0;   // data grants taken while a fetch waited
  initial begin
    int ph;
    logic exp_own, own, resp_due;
    logic [DW+1:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check_eq("rst_gnt",    {if_gnt, d_gnt}, 2'b00);
        check_eq("rst_rvalid", {if_rvalid, d_rvalid}, 2'b00);
        check_eq("rst_mem_req_we", {mem_req, mem_we}, 2'b00);
        check_eq("rst_mem_fields", {mem_addr, mem_wdata}, 64'd0);
        check_eq("rst_mem_wstrb", mem_wstrb, '0);
        check_eq("rst_state", dbg_state, IDLE);
        mphase = 0; skips = 0;
        exp_q.delete(); exp_mem_q.delete();
        continue;
      end
      ph = mphase;
      resp_due = 0;
      if (if_gnt && d_gnt) check_eq("gnt_exclusive", {if_gnt, d_gnt}, 2'b00);

      // grant prediction
      if (ph == 0) begin
        check_eq("idle_state", dbg_state, IDLE);
        if (if_req || d_req) begin
          // fetch waits for data unless it has already been passed over MAXS times
          if (if_req && d_req) exp_own = (skips >= MAXS) ? OWN_IF : OWN_D;
          else                 exp_own = if_req ? OWN_IF : OWN_D;
          check_eq("grant_if", if_gnt, exp_own == OWN_IF);
          check_eq("grant_d",  d_gnt,  exp_own == OWN_D);
          if (if_gnt || d_gnt) begin
            own = d_gnt ? OWN_D : OWN_IF;
            grant_log.push_back(own);
            mphase = 1;
            if (own == OWN_IF) begin
              skips = 0;
              exp_mem_q.push_back('{we: 1'b0, addr: if_addr, wdata: '0, wstrb: '0});
              exp_q.push_back({OWN_IF, 1'b0, ref_rd(if_addr)});
            end else begin
              skips = if_req ? skips + 1 : 0;
              exp_mem_q.push_back('{we: d_we, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb});
              if (d_we) begin
                ref_mem[d_addr] = merge(ref_rd(d_addr), d_wdata, d_wstrb);
                exp_q.push_back({OWN_D, 1'b1, {DW{1'b0}}});
              end else begin
                exp_q.push_back({OWN_D, 1'b0, ref_rd(d_addr)});
              end
            end
          end
        end else if (if_gnt || d_gnt) begin
          check_eq("gnt_without_req", {if_gnt, d_gnt}, 2'b00);
        end
      end else if (if_gnt || d_gnt) begin
        check_eq("gnt_while_busy", {if_gnt, d_gnt}, 2'b00);
      end

      // memory-side request
      if (ph == 1) begin
        check_eq("mem_req_held", mem_req, 1'b1);
        if (exp_mem_q.size() > 0) begin
          check_eq("mem_addr", mem_addr, exp_mem_q[0].addr);
          check_eq("mem_we", mem_we, exp_mem_q[0].we);
          check_eq("mem_wstrb", mem_wstrb, exp_mem_q[0].wstrb);
          if (exp_mem_q[0].we) check_eq("mem_wdata", mem_wdata, exp_mem_q[0].wdata);
        end
        if (mem_gnt) begin
          if (exp_mem_q.size() > 0) void'(exp_mem_q.pop_front());
          if (mem_rvalid) begin
            resp_due = 1; mphase = 0;
          end else begin
            mphase = 2;
          end
        end
      end else if (ph == 2) begin
        check_eq("mem_req_dropped", mem_req, 1'b0);
        if (mem_rvalid) begin
          resp_due = 1; mphase = 0;
        end
      end

      // response routing
      if (resp_due) begin
        if (exp_q.size() == 0) begin
          check_eq("resp_queue_empty", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_eq("rvalid_if", if_rvalid, e[DW+1] == OWN_IF);
          check_eq("rvalid_d",  d_rvalid,  e[DW+1] == OWN_D);
          if (e[DW+1] == OWN_IF) last_if_rdata = if_rdata;
          else                   last_d_rdata  = d_rdata;
          if (!e[DW]) begin
            if (e[DW+1] == OWN_IF) check_eq("if_rdata", if_rdata, e[DW-1:0]);
            else                   check_eq("d_rdata",  d_rdata,  e[DW-1:0]);
          end
        end
      end else if (mem_rvalid || if_rvalid || d_rvalid) begin
        check_eq("no_rvalid", {if_rvalid, d_rvalid}, 2'b00);
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  // Each task starts and ends just after a rising edge.
  task automatic do_fetch(input logic [AW-1:0] a);
    bit got;
    got = 0;
    if_req = 1; if_addr = a;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (if_gnt) begin got = 1; break; end
    end
    if (!got) check_eq("fetch_gnt_timeout", got, 1'b1);
    @(posedge clk); #1;
    if_req = 0; if_addr = $urandom;
  endtask

  task automatic do_data(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] st);
    bit got;
    got = 0;
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = st;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (d_gnt) begin got = 1; break; end
    end
    if (!got) check_eq("data_gnt_timeout", got, 1'b1);
    @(posedge clk); #1;
    d_req = 0; d_we = $urandom; d_addr = $urandom; d_wdata = $urandom; d_wstrb = $urandom;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (mphase == 0 && exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check_eq("idle_timeout", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return 32'h0000_1000 + AW'($urandom_range(0, 7) << 2);
  endfunction

  // ---------------------------------------------------------------- test sequence
  initial begin
    logic exp_seq [12];
    bit   seen;
    reset_n = 0;
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    last_if_rdata = '0; last_d_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;

    // single fetch with slow memory
    preload(32'h100, 32'h0050_0093);
    cfg_gd = 2; cfg_rd = 3;
    do_fetch(32'h100);
    wait_idle();
    check_eq("fetch_0x100_rdata", last_if_rdata, 32'h0050_0093);

    // simultaneous fetch and data write: data first, then fetch
    cfg_gd = 1; cfg_rd = 1;
    grant_log.delete();
    fork
      do_fetch(32'h300);
      do_data(1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF);
    join
    wait_idle();
    check_eq("tie_order_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check_eq("tie_first_data", grant_log[0], OWN_D);
      check_eq("tie_then_fetch", grant_log[1], OWN_IF);
    end

    // read back with mem_gnt and mem_rvalid in the same cycle
    cfg_gd = 1; cfg_rd = 0;
    do_data(1'b0, 32'h200, 32'h0, 4'h0);
    wait_idle();
    check_eq("readback_0x200", last_d_rdata, 32'hDEAD_BEEF);

    // data held continuously against a waiting fetch
    cfg_gd = 0; cfg_rd = 1;
    grant_log.delete();
    exp_seq = '{OWN_D, OWN_D, OWN_D, OWN_D, OWN_IF, OWN_D, OWN_D, OWN_D, OWN_D, OWN_IF, OWN_D, OWN_D};
    fork
      begin
        do_fetch(32'h400);
        do_fetch(32'h404);
      end
      begin
        for (int i = 0; i < 10; i++) do_data(1'b1, 32'h240 + 32'(i * 4), $urandom, 4'hF);
      end
    join
    wait_idle();
    check_eq("streak_count", grant_log.size(), 12);
    for (int i = 0; i < 12 && i < grant_log.size(); i++)
      check_eq($sformatf("streak_order_%0d", i), grant_log[i], exp_seq[i]);

    // randomized traffic with stray responses
    cfg_gd = -1; cfg_rd = -1; cfg_spur = 1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          for (int g = $urandom_range(0, 3); g > 0; g--) begin @(posedge clk); #1; end
          do_fetch(rand_addr());
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          for (int g = $urandom_range(0, 3); g > 0; g--) begin @(posedge clk); #1; end
          do_data($urandom_range(0, 1), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
        end
      end
    join
    wait_idle();

    // quiet window: stray mem_rvalid pulses while idle
    repeat (30) @(posedge clk);
    #1 cfg_spur = 0;
    repeat (4) @(posedge clk);
    #1;

    // reset while a response is pending, then the late response arrives
    cfg_gd = 0; cfg_rd = 5;
    do_fetch(32'h104);
    seen = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (mem_gnt) begin seen = 1; break; end
    end
    check_eq("wait_mem_gnt", seen, 1'b1);
    @(posedge clk); #1 reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (mem_rvalid) seen = 1;
      if (if_rvalid || d_rvalid) check_eq("post_reset_rvalid", {if_rvalid, d_rvalid}, 2'b00);
    end
    check_eq("late_mem_rvalid_seen", seen, 1'b1);
    check_eq("post_reset_mem", {mem_req, mem_we, mem_wstrb}, 6'd0);
    check_eq("post_reset_addr", mem_addr, 32'd0);
    check_eq("post_reset_state", dbg_state, IDLE);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/rv32_mem_arbiter.md
RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width; DW, default 32, data width; MAX_STREAK, default 4, consecutive data grants allowed while fetch waits.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  fetch request; fields stable while high until if_gnt.
REQ-005 if_addr  input  AW  fetch address.
REQ-006 if_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-007 if_rvalid  output  1  fetch read data valid.
REQ-008 if_rdata  output  DW  fetch read data.
REQ-009 d_req  input  1  data request; fields stable while high until d_gnt.
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_addr  input  AW  data address.
REQ-012 d_wdata  input  DW  write data.
REQ-013 d_wstrb  input  DW/8  byte write strobes.
REQ-014 d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-015 d_rvalid  output  1  data response (read data or write acknowledge).
REQ-016 d_rdata  output  DW  data read data.
REQ-017 mem_req, mem_we, mem_addr[AW], mem_wdata[DW], mem_wstrb[DW/8]  outputs  shared memory request, registered.
REQ-018 mem_gnt  input  1  memory accepts the request this cycle.
REQ-019 mem_rvalid  input  1  memory response, one per accepted request; mem_rdata  input  DW.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, WAIT; at most one transaction is outstanding.
REQ-021 IDLE, any request high: select a winner, pulse its gnt the same cycle, latch its fields into the mem_* registers, record owner, go to REQ.
REQ-022 Selection: data wins over fetch, except when streak == MAX_STREAK and if_req = 1, in which case fetch wins.
REQ-023 Streak counter: +1 on a data grant with if_req = 1; cleared on a fetch grant or on a data grant with if_req = 0; never exceeds MAX_STREAK.
REQ-024 For a fetch grant: mem_we = 0 and mem_wstrb = 0; mem_wdata is don't-care.
REQ-025 REQ: mem_req = 1 with all fields held stable until mem_gnt; on mem_gnt go to WAIT, or to IDLE if mem_rvalid is also high that cycle.
REQ-026 WAIT: on mem_rvalid, return to IDLE; mem_req = 0.
REQ-027 Response routing SHALL be combinational: the owner's rvalid = mem_rvalid and the owner's rdata = mem_rdata in the same cycle; the non-owner's rvalid = 0.
REQ-028 mem_rvalid in IDLE, or in REQ without mem_gnt, SHALL be ignored and produce no rvalid.
REQ-029 Latency: gnt in cycle N, mem_req from N+1, rvalid in the mem_rvalid cycle; back-to-back issue from IDLE begins one cycle after the response.
REQ-030 if_gnt and d_gnt SHALL never be high in the same cycle; no gnt outside IDLE.

Reset
REQ-031 Reset SHALL force state IDLE, streak 0, and owner fetch; mem_req, mem_we, if_gnt, d_gnt, if_rvalid and d_rvalid = 0; mem_addr, mem_wdata and mem_wstrb = 0.
REQ-032 Reset asserted mid-transaction SHALL drop the transaction; no rvalid is produced for it after release.

Structure
REQ-033 Package rv32_mem_pkg SHALL hold the state enum (IDLE/REQ/WAIT), the owner constants (OWN_IF = 0, OWN_D = 1) and the MAX_STREAK default.
REQ-034 A single sub-module, rv32_arb_select, SHALL implement the combinational winner selection from the request inputs and the streak count.

Verification
REQ-035 Single fetch, addr 0x100, mem_gnt after 2 cycles, mem_rdata 0x00500093 after 3 -> one if_gnt; mem_addr 0x100 held stable; if_rvalid with 0x00500093; d_rvalid stays 0.
REQ-036 if_req and d_req rise in the same cycle (d write 0x200/0xDEADBEEF/strb 0xF) -> d_gnt first, mem_we = 1 and mem_wstrb = 0xF; fetch is granted after the d_rvalid.
REQ-037 d_req held high continuously with if_req high, MAX_STREAK = 4 -> exactly 4 d_gnt, then 1 if_gnt, then streak restarts.
REQ-038 mem_gnt and mem_rvalid in the same cycle in REQ -> the owner rvalid pulses and the FSM returns to IDLE.
REQ-039 reset_n pulsed low in WAIT, then mem_rvalid arrives -> no rvalid; all outputs are at reset values.
REQ-040 Spurious mem_rvalid in IDLE -> if_rvalid = d_rvalid = 0; state unchanged.
